// File: rtl/mon_pkg.sv
// Shared definitions for the UART boot monitor and its transmit helper.
package mon_pkg;

  localparam int AW     = 9;  // RAM address width (512 bytes)
  localparam int RD_LAT = 2;  // RAM read latency in cycles, also assumed by the CPU

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

  typedef enum logic [3:0] {
    IDLE, CMD_HI, CMD_LO, CMD_LEN, LDATA, DREAD, DWAIT1, DWAIT2,
    TXREQ, TXGUARD, GSTART, RUN, RESP
  } state_e;

  typedef enum logic [1:0] {OP_LOAD, OP_DUMP, OP_GO} op_e;

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND, TX_GUARD} tx_state_e;

endpackage

// File: rtl/mon_tx.sv
// One-byte transmit handshake: waits for the UART to go idle, strobes the
// byte for one cycle, then spends one guard cycle ignoring is_transmitting
// because the UART busy flag only rises a cycle after the strobe.
//
// state    | meaning
// TX_IDLE  | ready; a request latches the byte
// TX_WAIT  | waiting for is_transmitting = 0
// TX_SEND  | transmit strobe cycle
// TX_GUARD | busy flag not trusted yet; done pulses here
module mon_tx
  import mon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       is_transmitting_i,
  output logic [7:0] tx_byte_o,
  output logic       transmit_o,
  output logic       done_o
);

  tx_state_e  state_q, state_d;
  logic [7:0] byte_q, byte_d;

  // state and held byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

  // accept -> wait for idle UART -> strobe -> guard
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    case (state_q)
      TX_IDLE: begin
        if (req_i) begin
          byte_d  = byte_i;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT:  if (!is_transmitting_i) state_d = TX_SEND;
      TX_SEND:  state_d = TX_GUARD;
      TX_GUARD: state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    tx_byte_o  = byte_q;
    transmit_o = (state_q == TX_SEND);
    done_o     = (state_q == TX_GUARD);
  end

endmodule

// File: rtl/uart_monitor.sv
// Serial boot monitor in front of the 8-bit CPU: load RAM, dump RAM and
// start the CPU from byte commands, then hand the bus over until it halts.
//
// state   | meaning
// IDLE    | waiting for an opcode
// CMD_HI  | waiting for addr_hi (only bit 0 kept)
// CMD_LO  | waiting for addr_lo
// CMD_LEN | waiting for length (0 = 256)
// LDATA   | receiving load data, one RAM write per byte
// DREAD   | dump: read address presented
// DWAIT1  | dump: first read latency cycle
// DWAIT2  | dump: read data valid, latched
// TXREQ   | dump: byte handed to the transmitter
// TXGUARD | dump: byte sent, advance address / count
// GSTART  | CPU owns bus, start strobe follows
// RUN     | CPU running, monitor ignores rx
// RESP    | sending ACK or ERR byte
module uart_monitor
  import mon_pkg::*;
#(
  parameter logic [23:0] TIMEOUT  = 24'd12_000_000,
  parameter logic [7:0]  ACK_BYTE = 8'h2E,
  parameter logic [7:0]  ERR_BYTE = 8'h3F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          received,
  input  logic [7:0]    rx_byte,
  input  logic          is_transmitting,
  output logic [7:0]    mon_tx_byte,
  output logic          mon_transmit,
  output logic [AW-1:0] ram_raddr,
  input  logic [7:0]    ram_rdata,
  output logic [AW-1:0] ram_waddr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  output logic          cpu_start,
  output logic [AW-1:0] cpu_startaddr,
  input  logic          cpu_halted,
  output logic          cpu_owns,
  output logic          busy
);

  localparam logic [23:0]   TMO_RELOAD = TIMEOUT - 24'd1;
  localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic [8:0]    len_q, len_d;  // bytes still to go, 1..256
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    txb_q, txb_d;
  logic          we_q, we_d;
  logic          start_q, start_d;
  logic [23:0]   timer_q, timer_d;
  logic          tx_req, tx_done;

  mon_tx u_tx (
    .clk               (clk),
    .rst               (rst),
    .req_i             (tx_req),
    .byte_i            (txb_q),
    .is_transmitting_i (is_transmitting),
    .tx_byte_o         (mon_tx_byte),
    .transmit_o        (mon_transmit),
    .done_o            (tx_done)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_LOAD;
      addr_q       <= '0;
      waddr_q      <= '0;
      start_addr_q <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      txb_q        <= '0;
      we_q         <= 1'b0;
      start_q      <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      waddr_q      <= waddr_d;
      start_addr_q <= start_addr_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      txb_q        <= txb_d;
      we_q         <= we_d;
      start_q      <= start_d;
      timer_q      <= timer_d;
    end
  end

  // command decode, inter-byte timeout, dump sequencing and CPU hand-over
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    waddr_d      = waddr_q;
    start_addr_d = start_addr_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    txb_d        = txb_q;
    timer_d      = timer_q;
    we_d         = 1'b0;
    start_d      = 1'b0;

    // a byte arriving in the expiry cycle wins: only idle cycles count down
    if ((state_q inside {CMD_HI, CMD_LO, CMD_LEN, LDATA}) && !received) begin
      if (timer_q == '0) begin
        txb_d   = ERR_BYTE;
        state_d = RESP;
      end else begin
        timer_d = timer_q - 24'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (received) begin
          timer_d = TMO_RELOAD;
          state_d = CMD_HI;
          case (rx_byte)
            CMD_LOAD: op_d = OP_LOAD;
            CMD_DUMP: op_d = OP_DUMP;
            CMD_GO:   op_d = OP_GO;
            default: begin
              txb_d   = ERR_BYTE;
              state_d = RESP;
            end
          endcase
        end
      end
      CMD_HI: begin
        if (received) begin
          addr_d  = {rx_byte[0], addr_q[AW-2:0]};
          timer_d = TMO_RELOAD;
          state_d = CMD_LO;
        end
      end
      CMD_LO: begin
        if (received) begin
          addr_d  = {addr_q[AW-1], rx_byte};
          timer_d = TMO_RELOAD;
          if (op_q == OP_GO) begin
            start_addr_d = {addr_q[AW-1], rx_byte};
            state_d      = GSTART;
          end else begin
            state_d = CMD_LEN;
          end
        end
      end
      CMD_LEN: begin
        if (received) begin
          len_d   = {rx_byte == 8'd0, rx_byte};
          timer_d = TMO_RELOAD;
          state_d = (op_q == OP_LOAD) ? LDATA : DREAD;
        end
      end
      LDATA: begin
        if (received) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rx_byte;
          addr_d  = addr_q + ADDR_ONE;
          len_d   = len_q - 9'd1;
          timer_d = TMO_RELOAD;
          if (len_q == 9'd1) begin
            txb_d   = ACK_BYTE;
            state_d = RESP;
          end
        end
      end
      DREAD:  state_d = DWAIT1;
      DWAIT1: state_d = DWAIT2;
      DWAIT2: begin
        txb_d   = ram_rdata;
        state_d = TXREQ;
      end
      TXREQ: if (tx_done) state_d = TXGUARD;
      TXGUARD: begin
        addr_d  = addr_q + ADDR_ONE;
        len_d   = len_q - 9'd1;
        state_d = (len_q == 9'd1) ? IDLE : DREAD;
      end
      GSTART: begin
        start_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (cpu_halted) begin
          txb_d   = ACK_BYTE;
          state_d = RESP;
        end
      end
      RESP:    if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state and registers
  always_comb begin
    busy          = (state_q != IDLE);
    cpu_owns      = (state_q == GSTART) || (state_q == RUN);
    cpu_start     = start_q;
    cpu_startaddr = start_addr_q;
    ram_raddr     = addr_q;
    ram_waddr     = waddr_q;
    ram_wdata     = wdata_q;
    ram_we        = we_q;
    tx_req        = (state_q == TXREQ) || (state_q == RESP);
  end

endmodule

// File: tb/tb_uart_monitor.sv
// Directed bench for uart_monitor: table of command vectors plus hand-written
// sequences for go/halt, timeout, full-page dump and mid-command reset.
module tb_uart_monitor;
  import mon_pkg::*;

  localparam logic [23:0] TMO     = 24'd100;
  localparam int          TX_BUSY = 10;
  localparam int          NV      = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          received = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          is_transmitting;
  logic [7:0]    mon_tx_byte;
  logic          mon_transmit;
  logic [AW-1:0] ram_raddr, ram_waddr, cpu_startaddr;
  logic [7:0]    ram_rdata, ram_wdata;
  logic          ram_we, cpu_start, cpu_owns, busy;
  logic          cpu_halted = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_monitor #(.TIMEOUT(TMO), .ACK_BYTE(8'h2E), .ERR_BYTE(8'h3F)) dut (
    .clk             (clk),
    .rst             (rst),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_transmitting (is_transmitting),
    .mon_tx_byte     (mon_tx_byte),
    .mon_transmit    (mon_transmit),
    .ram_raddr       (ram_raddr),
    .ram_rdata       (ram_rdata),
    .ram_waddr       (ram_waddr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .cpu_start       (cpu_start),
    .cpu_startaddr   (cpu_startaddr),
    .cpu_halted      (cpu_halted),
    .cpu_owns        (cpu_owns),
    .busy            (busy)
  );

  // RAM model: pattern-filled, RD_LAT-cycle read pipe, logs every write
  logic [7:0]  mem [512];
  logic [7:0]  rd_pipe [RD_LAT];
  logic        mem_init = 1'b0;
  logic [16:0] wr_log [$];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[ram_raddr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i * 7 + 3);
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
      wr_log.push_back({ram_waddr, ram_wdata});
    end
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  // UART transmitter model: busy rises one cycle after the strobe
  logic       tx_lag = 1'b0;
  int         tx_cnt = 0;
  int         tx_viol = 0;
  logic [7:0] tx_log [$];
  always @(posedge clk) begin
    tx_lag <= mon_transmit;
    if (mon_transmit) begin
      tx_log.push_back(mon_tx_byte);
      if (is_transmitting) tx_viol <= tx_viol + 1;
    end
    if (tx_lag) tx_cnt <= TX_BUSY;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign is_transmitting = (tx_cnt != 0);

  typedef struct {
    string            name;
    int               nrx;
    logic [7:0][7:0]  rx;   // stream byte i is rx[nrx-1-i]
    int               ntx;
    logic [3:0][7:0]  tx;
    int               nwr;
    logic [3:0][16:0] wr;   // {addr, data}
  } vec_t;
  vec_t vecs [NV];

  int tx0, wr0, n;
  logic [8:0]  act_tx;
  logic [17:0] act_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setv(input int k, input string nm, input int nrx, input logic [63:0] rx,
                      input int ntx, input logic [31:0] tx, input int nwr, input logic [67:0] wr);
    vecs[k].name = nm;
    vecs[k].nrx  = nrx;
    vecs[k].rx   = rx;
    vecs[k].ntx  = ntx;
    vecs[k].tx   = tx;
    vecs[k].nwr  = nwr;
    vecs[k].wr   = wr;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while (busy && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    check({name, " returns idle"}, 64'(busy), 64'(0));
  endtask

  task automatic check_tx(input string name, input int idx, input logic [7:0] exp);
    act_tx = (idx < tx_log.size()) ? {1'b0, tx_log[idx]} : 9'h100;
    check(name, 64'(act_tx), 64'({1'b0, exp}));
  endtask

  initial begin
    setv(0, "load", 7, 64'({8'h4C, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC}), 1, 32'(8'h2E),
         3, 68'({9'h010, 8'hAA, 9'h011, 8'hBB, 9'h012, 8'hCC}));
    setv(1, "dump", 4, 64'({8'h44, 8'h00, 8'h10, 8'h03}), 3, 32'({8'hAA, 8'hBB, 8'hCC}), 0, 68'(0));
    setv(2, "load_wrap", 6, 64'({8'h4C, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22}), 1, 32'(8'h2E),
         2, 68'({9'h1FF, 8'h11, 9'h000, 8'h22}));
    setv(3, "dump_wrap", 4, 64'({8'h44, 8'h01, 8'hFF, 8'h02}), 2, 32'({8'h11, 8'h22}), 0, 68'(0));
    setv(4, "bad_op", 1, 64'(8'h5A), 1, 32'(8'h3F), 0, 68'(0));
    setv(5, "load_hi_mask", 5, 64'({8'h4C, 8'hFE, 8'h05, 8'h01, 8'h77}), 1, 32'(8'h2E),
         1, 68'({9'h005, 8'h77}));
    setv(6, "dump_hi_mask", 4, 64'({8'h44, 8'h02, 8'h05, 8'h01}), 1, 32'(8'h77), 0, 68'(0));
    setv(7, "bad_op_lower", 1, 64'(8'h6C), 1, 32'(8'h3F), 0, 68'(0));
    // 0x123 untouched: pattern (0x123*7+3) & 0xFF = 0xF8
    setv(8, "dump_unwritten", 4, 64'({8'h44, 8'h01, 8'h23, 8'h01}), 1, 32'(8'hF8), 0, 68'(0));

    repeat (3) @(negedge clk);
    check("reset outputs", 64'({mon_tx_byte, mon_transmit, ram_raddr, ram_waddr, ram_wdata, ram_we,
                                cpu_start, cpu_startaddr, cpu_owns, busy}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      tx0 = tx_log.size();
      wr0 = wr_log.size();
      for (int i = 0; i < vecs[k].nrx; i++) send(vecs[k].rx[vecs[k].nrx-1-i]);
      wait_idle(vecs[k].name);
      repeat (2) @(negedge clk);
      check({vecs[k].name, " tx count"}, 64'(tx_log.size() - tx0), 64'(vecs[k].ntx));
      for (int i = 0; i < vecs[k].ntx; i++)
        check_tx({vecs[k].name, " tx byte"}, tx0 + i, vecs[k].tx[vecs[k].ntx-1-i]);
      check({vecs[k].name, " write count"}, 64'(wr_log.size() - wr0), 64'(vecs[k].nwr));
      for (int i = 0; i < vecs[k].nwr; i++) begin
        act_wr = (wr0 + i < wr_log.size()) ? {1'b0, wr_log[wr0+i]} : 18'h20000;
        check({vecs[k].name, " write"}, 64'(act_wr), 64'({1'b0, vecs[k].wr[vecs[k].nwr-1-i]}));
      end
    end

    // go / run / halt
    tx0 = tx_log.size();
    wr0 = wr_log.size();
    send(8'h47);
    send(8'h00);
    @(negedge clk);
    received = 1'b1;
    rx_byte  = 8'h20;
    @(negedge clk);
    received = 1'b0;
    check("go owns", 64'(cpu_owns), 64'(1));
    check("go startaddr", 64'(cpu_startaddr), 64'(9'h020));
    check("go start not yet", 64'(cpu_start), 64'(0));
    @(negedge clk);
    check("go start pulse", 64'(cpu_start), 64'(1));
    @(negedge clk);
    check("go start width", 64'(cpu_start), 64'(0));
    send(8'h5A);
    send(8'h4C);
    send(8'h00);
    repeat (20) @(negedge clk);
    check("run ignores rx tx", 64'(tx_log.size() - tx0), 64'(0));
    check("run ignores rx wr", 64'(wr_log.size() - wr0), 64'(0));
    check("run owns held", 64'(cpu_owns), 64'(1));
    check("run startaddr held", 64'(cpu_startaddr), 64'(9'h020));
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    check("halt releases bus", 64'(cpu_owns), 64'(0));
    wait_idle("halt");
    repeat (2) @(negedge clk);
    check("halt tx count", 64'(tx_log.size() - tx0), 64'(1));
    check_tx("halt ack", tx0, 8'h2E);

    // halt strobe outside RUN is ignored
    tx0 = tx_log.size();
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    repeat (20) @(negedge clk);
    check("stray halt busy", 64'(busy), 64'(0));
    check("stray halt tx", 64'(tx_log.size() - tx0), 64'(0));

    // timeout after addr_hi
    tx0 = tx_log.size();
    wr0 = wr_log.size();
    send(8'h4C);
    @(negedge clk);
    received = 1'b1;
    rx_byte  = 8'h00;
    @(negedge clk);
    received = 1'b0;
    n = 0;
    while (tx_log.size() == tx0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("timeout not early", 64'(n >= int'(TMO)), 64'(1));
    check("timeout not late", 64'(n <= int'(TMO) + 10), 64'(1));
    wait_idle("timeout");
    check_tx("timeout err", tx0, 8'h3F);
    check("timeout no write", 64'(wr_log.size() - wr0), 64'(0));

    // slow but in-time bytes keep the command alive
    tx0 = tx_log.size();
    wr0 = wr_log.size();
    send(8'h4C); repeat (80) @(negedge clk);
    send(8'h00); repeat (80) @(negedge clk);
    send(8'h40); repeat (80) @(negedge clk);
    send(8'h01); repeat (80) @(negedge clk);
    send(8'h99);
    wait_idle("slow load");
    repeat (2) @(negedge clk);
    check("slow load tx count", 64'(tx_log.size() - tx0), 64'(1));
    check_tx("slow load ack", tx0, 8'h2E);
    check("slow load write count", 64'(wr_log.size() - wr0), 64'(1));
    check("slow load write", 64'(wr_log[wr0]), 64'({9'h040, 8'h99}));

    // len 0 dumps a full 256-byte page
    tx0 = tx_log.size();
    send(8'h44); send(8'h00); send(8'h00); send(8'h00);
    wait_idle("dump256");
    repeat (2) @(negedge clk);
    check("dump256 count", 64'(tx_log.size() - tx0), 64'(256));
    for (int i = 0; i < 256; i++) check_tx("dump256 byte", tx0 + i, mem[i]);
    check("tx while busy", 64'(tx_viol), 64'(0));

    // reset in the middle of a load
    wr0 = wr_log.size();
    send(8'h4C); send(8'h00); send(8'h30); send(8'h03); send(8'hAA);
    rst = 1'b1;
    @(negedge clk);
    check("midreset outputs", 64'({mon_tx_byte, mon_transmit, ram_raddr, ram_waddr, ram_wdata, ram_we,
                                   cpu_start, cpu_startaddr, cpu_owns, busy}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset write count", 64'(wr_log.size() - wr0), 64'(1));
    check("midreset partial write", 64'(wr_log[wr0]), 64'({9'h030, 8'hAA}));
    tx0 = tx_log.size();
    send(8'h44); send(8'h00); send(8'h30); send(8'h01);
    wait_idle("post-reset dump");
    repeat (2) @(negedge clk);
    check("post-reset dump count", 64'(tx_log.size() - tx0), 64'(1));
    check_tx("post-reset dump byte", tx0, 8'hAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_monitor.md
Name: uart_monitor

Overview:
- Serial boot monitor that sits directly upstream of the 8-bit CPU.
- Accepts byte commands from the UART receiver to load RAM, dump RAM and start the CPU at a given address.
- While the CPU runs, it hands the RAM ports and the UART over to the CPU. When the CPU halts, it takes them back and sends an acknowledge byte.

Parameters:
- TIMEOUT, 24'd12_000_000: idle clock cycles allowed between bytes of one command before the command is aborted.
- ACK_BYTE, 8'h2E: byte sent after a completed L or G command ('.').
- ERR_BYTE, 8'h3F: byte sent on an unknown command or a timeout ('?').

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- received  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- is_transmitting  in  1  UART transmitter busy
- mon_tx_byte  out  8  byte to transmit
- mon_transmit  out  1  one-cycle transmit strobe
- ram_raddr  out  9  RAM read address; data is valid 2 cycles after presentation
- ram_rdata  in  8  RAM read data
- ram_waddr  out  9  RAM write address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable, one cycle per byte
- cpu_start  out  1  one-cycle start strobe, drives the CPU rst/start input
- cpu_startaddr  out  9  CPU start address, held stable while the CPU owns the bus
- cpu_halted  in  1  one-cycle halt strobe from the CPU
- cpu_owns  out  1  1 = top-level muxes route RAM ports and UART tx/rx to the CPU
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0.
  - Covers mon_tx_byte, mon_transmit, ram_raddr, ram_waddr, ram_wdata, ram_we, cpu_start, cpu_startaddr, cpu_owns and busy.
  - Reset mid-command or mid-run forces IDLE and cpu_owns=0. The CPU is not otherwise notified.
- Command framing: first byte is the opcode. Address is two bytes, addr_hi then addr_lo. Only addr_hi[0] is used; addr = {addr_hi[0], addr_lo}. len byte 0 means 256.
- 'L' (0x4C): addr, len, then len data bytes.
  - Each data byte: ram_waddr=addr, ram_wdata=byte, ram_we=1 for one cycle in the cycle after received. Then addr increments.
  - Addresses wrap mod 512 (0x1FF -> 0x000).
  - After the last byte, send ACK_BYTE.
- 'D' (0x44): addr, len.
  - For each byte: drive ram_raddr, wait 2 cycles, latch ram_rdata, then transmit it. Increment addr with mod-512 wrap.
  - No ACK after the dump.
- 'G' (0x47): addr.
  - cpu_startaddr=addr, cpu_owns=1. One cycle later, cpu_start=1 for exactly one cycle. Go to RUN.
  - RUN: ignore received entirely.
  - On cpu_halted, in the following cycle: cpu_owns=0, then send ACK_BYTE and return to IDLE.
- Any other opcode: send ERR_BYTE, then IDLE.
- Timeout: a counter resets on every received byte inside a command.
  - When it reaches TIMEOUT: send ERR_BYTE and go to IDLE. Partial L writes already done remain.
  - The counter is inactive in IDLE, RUN and while dumping.
- Transmit handshake:
  - Wait until is_transmitting=0, then mon_tx_byte=byte and mon_transmit=1 for one cycle.
  - Then one mandatory guard cycle in which is_transmitting is not sampled (UART busy flag lags by one cycle).
  - Applies to every ACK, ERR and dump byte.
- Bytes received while the monitor is transmitting ACK or ERR are dropped. Bytes received during a dump are dropped.
- States: IDLE, CMD_HI, CMD_LO, CMD_LEN, LDATA, DREAD, DWAIT1, DWAIT2, TXREQ, TXGUARD, GSTART, RUN, RESP.
- Simultaneous events:
  - received and timeout expiry in the same cycle: received wins.
  - cpu_halted outside RUN: ignored.

Decomposition:
- Shared package mon_pkg contains:
  - Command opcodes CMD_LOAD, CMD_DUMP and CMD_GO.
  - State encoding.
  - RAM address width constant AW=9.
  - RAM read latency constant RD_LAT=2 (shared with the CPU).
- One sub-module: mon_tx, the one-byte transmit handshake.
  - Handshake: req/byte in, done pulse out.
  - Contains the is_transmitting wait and the guard cycle.
  - Instanced once; ACK, ERR and dump bytes all use it.

Test Plan:
- Load: rx 4C 00 10 03 AA BB CC -> ram_we pulses writing 0x010=AA, 0x011=BB, 0x012=CC; then tx 2E.
- Wrap/len0: rx 4C 01 FF 02 11 22 -> writes 0x1FF=11, 0x000=22. A separate D 00 00 00 transmits 256 bytes, with mon_transmit never asserted while is_transmitting=1.
- Dump: after the load test, rx 44 00 10 03 -> tx AA BB CC in order; each ram_raddr-to-latch gap is exactly 2 cycles.
- Go/halt: rx 47 00 20 -> cpu_startaddr=0x020, cpu_owns=1, and cpu_start is one cycle wide one cycle later. Bytes rx during RUN produce no monitor action. Pulse cpu_halted -> cpu_owns=0, then tx 2E.
- Errors: rx 5A -> tx 3F. With TIMEOUT=100, rx 4C 00 and stall 100 cycles -> tx 3F, IDLE, no ram_we.
- Reset mid-L after 1 of 3 data bytes -> next cycle all outputs 0 and IDLE. A following D command works normally.
